gate_pool_tracker: RTL and testbench

Owns the gate-pool lock bitmap that feeds the gate allocator's `i_pool_lock` input. It accepts claim and release requests carrying 32-bit gate indices (the allocator's output format, with all-ones as the "no gate" sentinel). It applies them to a registered lock vector and reports free-gate count and protocol errors. It sits directly upstream of the allocator, and the allocator's `o_gates_idx` loops back into the claim port.

---
 rtl/gate_pool_tracker.sv | 124 ++++++++++++
 tb/tb_gate_pool_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_pool_tracker.sv
// Gate-pool lock bitmap: applies claim/release requests, tracks free count and sticky errors.
// Latency: one cycle from accepting edge to bitmap/count/ack/error outputs; flush clears one cycle later.
// Backpressure: both ports ready in RUN; both held off during the single FLUSH cycle.
module gate_pool_tracker #(
    parameter int POOL_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_claim_valid,
    input  logic [31:0]           i_claim_idx,
    output logic                  o_claim_ready,
    input  logic                  i_release_valid,
    input  logic [31:0]           i_release_idx,
    output logic                  o_release_ready,
    input  logic                  i_flush,
    input  logic                  i_clear_err,
    output logic [POOL_WIDTH-1:0] o_pool_lock,
    output logic [CNT_WIDTH-1:0]  o_free_count,
    output logic                  o_all_locked,
    output logic                  o_ack,
    output logic [1:0]            o_err_code
);

    localparam int IW = (POOL_WIDTH > 1) ? $clog2(POOL_WIDTH) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [POOL_WIDTH-1:0]   lock_q, lock_d, lock_mid;
    logic [CNT_WIDTH-1:0]    free_q, free_d;
    logic                    all_locked_q;
    logic                    ack_q, ack_d;
    logic [1:0]              err_q, err_d;
    logic [1:0]              rel_err, clm_err, new_err;
    logic                    rdy, rel_acc, clm_acc, rel_inr, clm_inr, inc, dec;
    logic [IW-1:0]           rel_bit, clm_bit;

    assign rdy     = (state_q == RUN);
    assign rel_acc = i_release_valid && rdy;
    assign clm_acc = i_claim_valid && rdy;
    assign rel_inr = (i_release_idx < 32'(POOL_WIDTH));
    assign clm_inr = (i_claim_idx < 32'(POOL_WIDTH));
    assign rel_bit = i_release_idx[IW-1:0];
    assign clm_bit = i_claim_idx[IW-1:0];

    // Release is resolved against the current bitmap, claim against the post-release one.
    always_comb begin
        lock_mid = lock_q;
        rel_err  = 2'b00;
        clm_err  = 2'b00;
        inc      = 1'b0;
        dec      = 1'b0;
        if (rel_acc) begin
            if (!rel_inr) begin
                rel_err = 2'b11;
            end else if (lock_q[rel_bit]) begin
                lock_mid[rel_bit] = 1'b0;
                inc               = 1'b1;
            end else begin
                rel_err = 2'b10;
            end
        end
        lock_d = lock_mid;
        if (clm_acc) begin
            if (!clm_inr) begin
                clm_err = 2'b11;
            end else if (lock_mid[clm_bit]) begin
                clm_err = 2'b01;
            end else begin
                lock_d[clm_bit] = 1'b1;
                dec             = 1'b1;
            end
        end
        free_d  = free_q + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
        new_err = (rel_err != 2'b00) ? rel_err : clm_err;
        ack_d   = rel_acc || clm_acc;
        state_d = RUN;
        if (state_q == RUN && i_flush) begin
            state_d = FLUSH;
        end
        if (state_q == FLUSH) begin
            lock_d = '0;
            free_d = CNT_WIDTH'(POOL_WIDTH);
        end
        if (i_clear_err) begin
            err_d = 2'b00;
        end else if (err_q == 2'b00) begin
            err_d = new_err;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            lock_q       <= '0;
            free_q       <= CNT_WIDTH'(POOL_WIDTH);
            all_locked_q <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            free_q       <= free_d;
            all_locked_q <= (free_d == '0);
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign o_claim_ready   = rdy;
    assign o_release_ready = rdy;
    assign o_pool_lock     = lock_q;
    assign o_free_count    = free_q;
    assign o_all_locked    = all_locked_q;
    assign o_ack           = ack_q;
    assign o_err_code      = err_q;

endmodule

// File: tb/tb_gate_pool_tracker.sv
// Bench for gate_pool_tracker: directed table, corner sequences, random traffic vs. array model.
module tb_gate_pool_tracker;

    localparam int P  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          claim_vld, rel_vld, flush, clear_err;
    logic [31:0]   claim_idx, rel_idx;
    logic          claim_rdy, rel_rdy, all_locked, ack;
    logic [P-1:0]  pool_lock;
    logic [CW-1:0] free_count;
    logic [1:0]    err_code;

    int n_tests = 0;
    int n_fail  = 0;

    bit       m_lock[P];
    bit       m_flush;
    bit       m_ack;
    logic [1:0] m_err;

    typedef struct {
        bit          cv;
        logic [31:0] ci;
        bit          rv;
        logic [31:0] ri;
        bit          fl;
        bit          ce;
        logic [31:0] exp_lock;
        int          exp_free;
        logic [1:0]  exp_err;
        bit          exp_ack;
    } vec_t;

    vec_t tbl[19];

    gate_pool_tracker #(.POOL_WIDTH(P), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_claim_valid   (claim_vld),
        .i_claim_idx     (claim_idx),
        .o_claim_ready   (claim_rdy),
        .i_release_valid (rel_vld),
        .i_release_idx   (rel_idx),
        .o_release_ready (rel_rdy),
        .i_flush         (flush),
        .i_clear_err     (clear_err),
        .o_pool_lock     (pool_lock),
        .o_free_count    (free_count),
        .o_all_locked    (all_locked),
        .o_ack           (ack),
        .o_err_code      (err_code)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit cv, logic [31:0] ci, bit rv, logic [31:0] ri, bit fl, bit ce,
                                logic [31:0] el, int ef, logic [1:0] ee, bit ea);
        vec_t v;
        v.cv = cv; v.ci = ci; v.rv = rv; v.ri = ri; v.fl = fl; v.ce = ce;
        v.exp_lock = el; v.exp_free = ef; v.exp_err = ee; v.exp_ack = ea;
        return v;
    endfunction

    function automatic logic [31:0] m_bitmap();
        logic [31:0] b = '0;
        for (int i = 0; i < P; i++) b[i] = m_lock[i];
        return b;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < P; i++) if (!m_lock[i]) n++;
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < P; i++) m_lock[i] = 1'b0;
        m_flush = 1'b0;
        m_ack   = 1'b0;
        m_err   = 2'b00;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_lock"},  64'(pool_lock),  64'(m_bitmap()));
        chk({tag, "_free"},  64'(free_count), 64'(m_free()));
        chk({tag, "_full"},  64'(all_locked), 64'(m_free() == 0));
        chk({tag, "_ack"},   64'(ack),        64'(m_ack));
        chk({tag, "_err"},   64'(err_code),   64'(m_err));
        chk({tag, "_crdy"},  64'(claim_rdy),  64'(!m_flush));
        chk({tag, "_rrdy"},  64'(rel_rdy),    64'(!m_flush));
    endtask

    // What one clock edge should do, given the inputs presented during the cycle before it.
    task automatic model_edge(input bit cv, input logic [31:0] ci, input bit rv,
                              input logic [31:0] ri, input bit fl, input bit ce);
        logic [1:0] e_rel = 2'b00;
        logic [1:0] e_clm = 2'b00;
        if (m_flush) begin
            for (int i = 0; i < P; i++) m_lock[i] = 1'b0;
            m_flush = 1'b0;
            m_ack   = 1'b0;
        end else begin
            m_ack = cv || rv;
            if (rv) begin
                if (ri >= P)          e_rel = 2'b11;
                else if (m_lock[ri])  m_lock[ri] = 1'b0;
                else                  e_rel = 2'b10;
            end
            if (cv) begin
                if (ci >= P)          e_clm = 2'b11;
                else if (m_lock[ci])  e_clm = 2'b01;
                else                  m_lock[ci] = 1'b1;
            end
            if (fl) m_flush = 1'b1;
        end
        if (ce)                 m_err = 2'b00;
        else if (m_err == 2'b00) m_err = (e_rel != 2'b00) ? e_rel : e_clm;
    endtask

    task automatic step(input bit cv, input logic [31:0] ci, input bit rv,
                        input logic [31:0] ri, input bit fl, input bit ce, input string tag);
        claim_vld = cv; claim_idx = ci; rel_vld = rv; rel_idx = ri;
        flush = fl; clear_err = ce;
        model_edge(cv, ci, rv, ri, fl, ce);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        tbl[0]  = mk(0, 0,  0, 0,  0, 0, 32'h0000_0000, 32, 2'b00, 0);
        tbl[1]  = mk(1, 3,  0, 0,  0, 0, 32'h0000_0008, 31, 2'b00, 1);
        tbl[2]  = mk(1, 31, 0, 0,  0, 0, 32'h8000_0008, 30, 2'b00, 1);
        tbl[3]  = mk(1, 3,  0, 0,  0, 0, 32'h8000_0008, 30, 2'b01, 1);
        tbl[4]  = mk(0, 0,  0, 0,  0, 0, 32'h8000_0008, 30, 2'b01, 0);
        tbl[5]  = mk(0, 0,  0, 0,  0, 1, 32'h8000_0008, 30, 2'b00, 0);
        tbl[6]  = mk(0, 0,  1, 5,  0, 0, 32'h8000_0008, 30, 2'b10, 1);
        tbl[7]  = mk(0, 0,  0, 0,  0, 1, 32'h8000_0008, 30, 2'b00, 0);
        tbl[8]  = mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h8000_0008, 30, 2'b11, 1);
        tbl[9]  = mk(1, 40, 0, 0,  0, 1, 32'h8000_0008, 30, 2'b00, 1);
        tbl[10] = mk(1, 40, 0, 0,  0, 0, 32'h8000_0008, 30, 2'b11, 1);
        tbl[11] = mk(0, 0,  0, 0,  0, 1, 32'h8000_0008, 30, 2'b00, 0);
        tbl[12] = mk(1, 7,  0, 0,  0, 0, 32'h8000_0088, 29, 2'b00, 1);
        tbl[13] = mk(1, 7,  1, 7,  0, 0, 32'h8000_0088, 29, 2'b00, 1);
        tbl[14] = mk(1, 5,  1, 3,  0, 0, 32'h8000_00A0, 29, 2'b00, 1);
        tbl[15] = mk(1, 9,  1, 9,  0, 0, 32'h8000_02A0, 28, 2'b10, 1);
        tbl[16] = mk(0, 0,  0, 0,  0, 1, 32'h8000_02A0, 28, 2'b00, 0);
        tbl[17] = mk(1, 5,  1, 4,  0, 0, 32'h8000_02A0, 28, 2'b10, 1);
        tbl[18] = mk(0, 0,  0, 0,  0, 1, 32'h8000_02A0, 28, 2'b00, 0);

        rst = 1'b0;
        claim_vld = 0; claim_idx = '0; rel_vld = 0; rel_idx = '0; flush = 0; clear_err = 0;
        m_reset();
        #12;
        check_model("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].cv, tbl[i].ci, tbl[i].rv, tbl[i].ri, tbl[i].fl, tbl[i].ce,
                 $sformatf("v%0d", i));
            chk($sformatf("v%0d_tlock", i), 64'(pool_lock),  64'(tbl[i].exp_lock));
            chk($sformatf("v%0d_tfree", i), 64'(free_count), 64'(tbl[i].exp_free));
            chk($sformatf("v%0d_terr",  i), 64'(err_code),   64'(tbl[i].exp_err));
            chk($sformatf("v%0d_tack",  i), 64'(ack),        64'(tbl[i].exp_ack));
        end

        // Fill the pool completely, then flush with a claim riding along.
        for (int i = 0; i < P; i++) step(1, i, 0, 0, 0, 0, $sformatf("fill%0d", i));
        step(0, 0, 0, 0, 0, 1, "fill_clr");
        chk("full_flag", 64'(all_locked), 64'(1));
        chk("full_cnt",  64'(free_count), 64'(0));
        chk("full_map",  64'(pool_lock),  64'(32'hFFFF_FFFF));

        step(1, 0, 0, 0, 1, 0, "flush_go");
        chk("flush_crdy_low", 64'(claim_rdy), 64'(0));
        chk("flush_rrdy_low", 64'(rel_rdy),   64'(0));
        step(1, 4, 1, 2, 1, 0, "flush_held");
        chk("post_flush_rdy",  64'(claim_rdy),  64'(1));
        chk("post_flush_map",  64'(pool_lock),  64'(0));
        chk("post_flush_cnt",  64'(free_count), 64'(32));
        chk("post_flush_ack",  64'(ack),        64'(0));
        step(0, 0, 0, 0, 0, 1, "flush_clr");

        // Reset asserted in the middle of a FLUSH cycle.
        step(1, 2, 0, 0, 0, 0, "pre_rst_a");
        step(1, 9, 0, 0, 1, 0, "pre_rst_b");
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check_model("rst_in_flush");
        chk("rst_map_now", 64'(pool_lock),  64'(0));
        chk("rst_cnt_now", 64'(free_count), 64'(32));
        #2;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, "after_rst");

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ci, ri;
            int r;
            r  = $urandom_range(0, 39);
            ci = (r >= 36) ? 32'hFFFF_FFFF : 32'(r);
            r  = $urandom_range(0, 39);
            ri = (r >= 36) ? 32'hFFFF_FFFF : 32'(r);
            step(bit'($urandom_range(0, 1)), ci, bit'($urandom_range(0, 1)), ri,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                 $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
